// File: rtl/count_display.sv
// Four-digit multiplexed 7-segment display for a 16-bit stopwatch count (binary -> BCD via double-dabble).
// Define COUNT_DISPLAY_LZB_EN to blank leading zeros left of the decimal-point digit.
module count_display #(
  parameter int DIGIT_PERIOD = 100000,
  parameter int DP_DIGIT     = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [15:0] Count,
  output logic [6:0]  Segments,
  output logic        Dp,
  output logic [3:0]  Anodes,
  output logic        Overflow
);

  localparam int             CW           = $clog2(DIGIT_PERIOD);
  localparam logic [CW-1:0]  REFRESH_LAST = CW'(DIGIT_PERIOD - 1);
  localparam bit             DP_EN        = (DP_DIGIT >= 0) && (DP_DIGIT < 4);
  localparam logic [1:0]     DP_IDX       = 2'(DP_DIGIT);
  localparam logic [3:0]     DIG_DASH     = 4'hA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state_q;
  logic [15:0]      bin_q;
  logic [19:0]      bcd_q;
  logic [3:0]       iter_q;
  logic [3:0][3:0]  digits_q;
  logic             overflow_q;
  logic [15:0]      bcdAdj_d;

  logic [CW-1:0]    refreshCnt_q;
  logic [CW-1:0]    refreshCnt_d;
  logic [1:0]       digitIdx_q;
  logic [1:0]       digitIdx_d;
  logic [3:0]       blank_d;
  logic [3:0]       curDigit_d;

  function automatic logic [6:0] segEncode(input logic [3:0] digit);
    case (digit)
      4'd0:    segEncode = 7'b1000000;
      4'd1:    segEncode = 7'b1111001;
      4'd2:    segEncode = 7'b0100100;
      4'd3:    segEncode = 7'b0110000;
      4'd4:    segEncode = 7'b0011001;
      4'd5:    segEncode = 7'b0010010;
      4'd6:    segEncode = 7'b0000010;
      4'd7:    segEncode = 7'b1111000;
      4'd8:    segEncode = 7'b0000000;
      4'd9:    segEncode = 7'b0010000;
      DIG_DASH: segEncode = 7'b0111111;
      default: segEncode = 7'b1111111;
    endcase
  endfunction

  // The ten-thousands digit never exceeds 4 before its final shift, so only the low four need the add-3.
  always_comb begin
    bcdAdj_d = bcd_q[15:0];
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bin_q   <= Count;
          bcd_q   <= '0;
          iter_q  <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          bcd_q  <= {bcd_q[18:16], bcdAdj_d, bin_q[15]};
          bin_q  <= {bin_q[14:0], 1'b0};
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd15) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (bcd_q[19:16] != 4'd0) begin
            overflow_q <= 1'b1;
            digits_q   <= {4{DIG_DASH}};
          end else begin
            overflow_q <= 1'b0;
            digits_q   <= bcd_q[15:0];
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    refreshCnt_d = refreshCnt_q + 1'b1;
    digitIdx_d   = digitIdx_q;
    if (refreshCnt_q == REFRESH_LAST) begin
      refreshCnt_d = '0;
      digitIdx_d   = digitIdx_q + 2'd1;
    end
  end

`ifdef COUNT_DISPLAY_LZB_EN
  // A digit is blanked only when it and everything left of it is zero, and it lies left of the decimal point.
  always_comb begin
    logic leftZero;
    leftZero = 1'b1;
    blank_d  = '0;
    for (int i = 3; i >= 1; i--) begin
      leftZero   = leftZero && (digits_q[i] == 4'd0);
      blank_d[i] = leftZero && (!DP_EN || (i > DP_DIGIT));
    end
  end
`else
  assign blank_d = '0;
`endif

  assign curDigit_d = digits_q[digitIdx_d];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      refreshCnt_q <= '0;
      digitIdx_q   <= '0;
      Anodes       <= 4'b1111;
      Segments     <= 7'h7F;
      Dp           <= 1'b1;
    end else begin
      refreshCnt_q <= refreshCnt_d;
      digitIdx_q   <= digitIdx_d;
      Anodes       <= ~(4'b0001 << digitIdx_d);
      Segments     <= blank_d[digitIdx_d] ? 7'h7F : segEncode(curDigit_d);
      Dp           <= !(DP_EN && (digitIdx_d == DP_IDX) && !overflow_q);
    end
  end

  assign Overflow = overflow_q;

endmodule

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 SHALL have parameter DIGIT_PERIOD, default 100000, clocks each digit is driven before advancing (minimum 2).
REQ-002 SHALL have parameter DP_DIGIT, default 2, digit index (0 = rightmost) whose decimal point is lit; a value of 4 or more means no decimal point.
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Count  input  16  unsigned binary value from the stopwatch counter.
REQ-006 SHALL have port Segments  output  7  active-low, bit order {g,f,e,d,c,b,a}.
REQ-007 SHALL have port Dp  output  1  active-low decimal point.
REQ-008 SHALL have port Anodes  output  4  active-low digit enables; Anodes[0] = ones digit.
REQ-009 SHALL have port Overflow  output  1  high while the latched value exceeds 9999.

Function
REQ-010 SHALL run the converter FSM continuously through IDLE -> SHIFT -> LOAD -> IDLE.
REQ-011 In IDLE, SHALL snapshot Count; later changes to Count SHALL NOT affect the conversion in progress.
REQ-012 In SHIFT, SHALL perform exactly 16 shift-add-3 (double-dabble) iterations, one per clock, into a 20-bit BCD register.
REQ-013 In LOAD, SHALL update the four display digits and Overflow atomically in one cycle; partially converted digits SHALL never reach outputs.
REQ-014 Latency SHALL be 18 clocks from the IDLE snapshot to updated display registers; conversions SHALL repeat every 18 clocks.
REQ-015 If the BCD ten-thousands digit is non-zero (Count > 9999), LOAD SHALL set Overflow = 1 and latch all four digits as dash (segment g only, Segments = 7'b0111111).
REQ-016 If Count <= 9999, LOAD SHALL clear Overflow.
REQ-017 A free-running refresh counter SHALL advance the digit index 0 -> 1 -> 2 -> 3 -> 0 every DIGIT_PERIOD clocks; index 3 SHALL wrap to 0.
REQ-018 Exactly one Anodes bit SHALL be low at a time after reset, selecting the current digit index.
REQ-019 Segments, Dp and Anodes SHALL be registered and SHALL change in the same cycle on each digit advance.
REQ-020 Segments SHALL encode BCD 0-9 in standard 7-segment form, e.g. 0 = 7'b1000000, 8 = 7'b0000000.
REQ-021 Dp SHALL be 0 only while the current digit index equals DP_DIGIT; in overflow, Dp SHALL be 1.

Reset
REQ-022 While Reset_n = 0, outputs SHALL be: Anodes = 4'b1111, Segments = 7'h7F, Dp = 1, Overflow = 0.
REQ-023 Reset SHALL clear the display digits to 0, the refresh counter and digit index to 0, and return the FSM to IDLE, including when asserted mid-SHIFT.
REQ-024 After Reset_n rises, the first snapshot SHALL occur on the first clock edge; Anodes SHALL be 4'b1110 from that edge.

Configuration
REQ-025 Macro COUNT_DISPLAY_LZB_EN SHALL control leading-zero blanking.
REQ-026 With COUNT_DISPLAY_LZB_EN defined, digits 3..1 that are zero and have only zeros to their left SHALL be blanked (Segments = 7'h7F).
REQ-027 With COUNT_DISPLAY_LZB_EN defined, digit 0 SHALL never be blanked, no digit at or right of DP_DIGIT SHALL be blanked, and Dp behaviour SHALL be unchanged.
REQ-028 Without COUNT_DISPLAY_LZB_EN, all four digits SHALL always be shown.

Verification (DIGIT_PERIOD = 4)
REQ-029 Count = 16'd1234, wait 18 clocks -> digits 3..0 scan as 1,2,3,4 (Segments 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001); Dp = 0 only on Anodes = 4'b1011.
REQ-030 Count = 16'd9999 -> all digits 7'b0010000, Overflow = 0; then Count = 16'd10000 -> within 36 clocks all digits 7'b0111111, Overflow = 1, Dp = 1 throughout.
REQ-031 Count = 16'd7 with COUNT_DISPLAY_LZB_EN -> digit 3 blank, digits 2..0 show 0,0,7; without the macro -> 0,0,0,7.
REQ-032 Count toggles 16'd1111 <-> 16'd2222 every clock -> every LOAD yields digits all 1 or all 2, never mixed.
REQ-033 Reset_n = 0 for 3 clocks during SHIFT -> reset outputs immediately; after release, the first display update carries the current Count 18 clocks later.
